// File: rtl/img_pkg.sv
// Shared image constants, zoom encodings and FSM state type for the
// pixel replication (nearest-neighbour upscaler) block.
package img_pkg;

  localparam int IMG_W_IN_DEF  = 160;
  localparam int IMG_H_IN_DEF  = 120;
  localparam int IMG_W_OUT_DEF = 320;
  localparam int IMG_H_OUT_DEF = 240;

  localparam int RD_ADDR_W = 15;
  localparam int WR_ADDR_W = 17;
  localparam int PIX_W     = 8;

  localparam logic [2:0] ZOOM_2X = 3'd0;
  localparam logic [2:0] ZOOM_4X = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Any encoding other than 4x falls back to the full-image 2x mode.
  function automatic logic [2:0] norm_zoom(input logic [2:0] zoom);
    return (zoom == ZOOM_4X) ? ZOOM_4X : ZOOM_2X;
  endfunction

endpackage

// File: rtl/replication_addr_gen.sv
// Combinational source-address generator: maps an output coordinate to the
// source pixel it replicates, for 2x full-image or 4x centre-crop zoom.
module replication_addr_gen
  import img_pkg::*;
#(
  parameter int IMG_W_IN = IMG_W_IN_DEF,
  parameter int IMG_H_IN = IMG_H_IN_DEF,
  parameter int XW       = 9,
  parameter int YW       = 8
) (
  input  logic [XW-1:0] x_out,
  input  logic [YW-1:0] y_out,
  input  logic [2:0]    zoom,
  output logic [14:0]   read_addr
);

  localparam int X_OFF = IMG_W_IN / 4;
  localparam int Y_OFF = IMG_H_IN / 4;

  logic        is_4x;
  logic [14:0] x_ext;
  logic [14:0] y_ext;
  logic [14:0] col;
  logic [14:0] row;
  logic [14:0] row_base;

  always_comb begin
    is_4x = (zoom == ZOOM_4X);
    x_ext = 15'(x_out);
    y_ext = 15'(y_out);
    col   = x_ext >> 1;
    row   = y_ext >> 1;
    if (is_4x) begin
      col = 15'(X_OFF) + (x_ext >> 2);
      row = 15'(Y_OFF) + (y_ext >> 2);
    end
  end

  // A 160-pixel row stride is 128 + 32, so no multiplier is needed there.
  generate
    if (IMG_W_IN == 160) begin : g_shift_add
      assign row_base = (row << 7) + (row << 5);
    end else begin : g_mult
      assign row_base = row * 15'(IMG_W_IN);
    end
  endgenerate

  assign read_addr = row_base + col;

endmodule

// File: rtl/pixel_replication.sv
// Frame sequencer: walks the destination raster, issues source reads and
// writes each fetched pixel two cycles later through a short pipeline.
module pixel_replication
  import img_pkg::*;
#(
  parameter int IMG_W_IN  = IMG_W_IN_DEF,
  parameter int IMG_H_IN  = IMG_H_IN_DEF,
  parameter int IMG_W_OUT = IMG_W_OUT_DEF,
  parameter int IMG_H_OUT = IMG_H_OUT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        start,
  input  logic [2:0]  zoom_level,
  input  logic [7:0]  pixel_in,
  output logic [14:0] read_addr,
  output logic [16:0] write_addr,
  output logic [7:0]  pixel_out,
  output logic        write_en,
  output logic        busy,
  output logic        done
);

  localparam int XW = $clog2(IMG_W_OUT);
  localparam int YW = $clog2(IMG_H_OUT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W_OUT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H_OUT - 1);

  state_t state_q;
  state_t state_d;

  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [2:0]    zoom_q;
  logic [16:0]   pix_cnt;
  logic [16:0]   k0;
  logic [16:0]   k1;
  logic          valid0;
  logic          valid1;
  logic          flush_cnt;
  logic          last_coord;
  logic [14:0]   addr_next;

  assign last_coord = (x_out == X_LAST) && (y_out == Y_LAST);

  replication_addr_gen #(
    .IMG_W_IN (IMG_W_IN),
    .IMG_H_IN (IMG_H_IN),
    .XW       (XW),
    .YW       (YW)
  ) u_addr_gen (
    .x_out     (x_out),
    .y_out     (y_out),
    .zoom      (zoom_q),
    .read_addr (addr_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN:   if (last_coord) state_d = ST_FLUSH;
        ST_FLUSH: if (flush_cnt) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Raster coordinate walk; zoom is captured only when a frame is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_out     <= '0;
      y_out     <= '0;
      pix_cnt   <= '0;
      zoom_q    <= ZOOM_2X;
      flush_cnt <= 1'b0;
    end else if (!enable) begin
      x_out     <= '0;
      y_out     <= '0;
      pix_cnt   <= '0;
      flush_cnt <= 1'b0;
    end else begin
      flush_cnt <= (state_q == ST_FLUSH) && !flush_cnt;
      if (state_q == ST_IDLE && start) begin
        zoom_q  <= norm_zoom(zoom_level);
        x_out   <= '0;
        y_out   <= '0;
        pix_cnt <= '0;
      end else if (state_q == ST_RUN) begin
        pix_cnt <= pix_cnt + 17'd1;
        if (x_out == X_LAST) begin
          x_out <= '0;
          if (y_out != Y_LAST) y_out <= y_out + 1'b1;
        end else begin
          x_out <= x_out + 1'b1;
        end
      end
    end
  end

  // Two-stage pipeline matching the one-cycle source memory read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_addr  <= '0;
      valid0     <= 1'b0;
      valid1     <= 1'b0;
      k0         <= '0;
      k1         <= '0;
      write_addr <= '0;
      pixel_out  <= '0;
      write_en   <= 1'b0;
    end else if (!enable) begin
      read_addr  <= '0;
      valid0     <= 1'b0;
      valid1     <= 1'b0;
      write_en   <= 1'b0;
    end else begin
      valid0   <= (state_q == ST_RUN);
      valid1   <= valid0;
      k1       <= k0;
      write_en <= valid1;
      if (state_q == ST_RUN) begin
        read_addr <= addr_next;
        k0        <= pix_cnt;
      end
      if (valid1) begin
        pixel_out  <= pixel_in;
        write_addr <= k1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (!enable) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == ST_RUN) || (state_d == ST_FLUSH);
      done <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_pixel_replication.sv
// Randomized self-checking bench: a reduced-height image keeps each frame short
// while the 160-wide stride still exercises the shift-add row multiply.
module tb_pixel_replication;

  localparam int W_IN  = 160;
  localparam int H_IN  = 8;
  localparam int W_OUT = 320;
  localparam int H_OUT = 16;
  localparam int NPIX  = W_OUT * H_OUT;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        start;
  logic [2:0]  zoom_level;
  logic [7:0]  pixel_in;
  logic [14:0] read_addr;
  logic [16:0] write_addr;
  logic [7:0]  pixel_out;
  logic        write_en;
  logic        busy;
  logic        done;

  logic [7:0] mem [0:32767];
  int passed;
  int total;

  pixel_replication #(
    .IMG_W_IN  (W_IN),
    .IMG_H_IN  (H_IN),
    .IMG_W_OUT (W_OUT),
    .IMG_H_OUT (H_OUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .start      (start),
    .zoom_level (zoom_level),
    .pixel_in   (pixel_in),
    .read_addr  (read_addr),
    .write_addr (write_addr),
    .pixel_out  (pixel_out),
    .write_en   (write_en),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous source memory: data appears the cycle after the address.
  always @(posedge clk) pixel_in <= mem[read_addr];

  // Nearest-neighbour source index for destination pixel k.
  function automatic int src_of(input int k, input bit zoom4);
    int x, y, s, xo, yo;
    x  = k % W_OUT;
    y  = k / W_OUT;
    s  = zoom4 ? 2 : 1;
    xo = zoom4 ? W_IN / 4 : 0;
    yo = zoom4 ? H_IN / 4 : 0;
    return (yo + (y >> s)) * W_IN + xo + (x >> s);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_read_addr"}, 32'(read_addr), 32'd0);
    checkOutput({tag, "_write_addr"}, 32'(write_addr), 32'd0);
    checkOutput({tag, "_pixel_out"}, 32'(pixel_out), 32'd0);
    checkOutput({tag, "_write_en"}, 32'(write_en), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Runs one frame from IDLE; abort_at >= 0 drops enable at that cycle.
  task automatic applyStimulus(input logic [2:0] zl, input int abort_at);
    bit zoom4;
    zoom4 = (zl == 3'd1);
    @(negedge clk);
    enable     = 1'b1;
    start      = 1'b1;
    zoom_level = zl;
    for (int t = 0; t <= NPIX + 4; t++) begin
      @(negedge clk);
      checkOutput("busy", 32'(busy), 32'(t <= NPIX + 1));
      checkOutput("done", 32'(done), 32'(t == NPIX + 2));
      checkOutput("write_en", 32'(write_en), 32'((t >= 3) && (t <= NPIX + 2)));
      if (t >= 1 && t <= NPIX)
        checkOutput("read_addr", 32'(read_addr), 32'(src_of(t - 1, zoom4)));
      if (t >= 3 && t <= NPIX + 2) begin
        checkOutput("write_addr", 32'(write_addr), 32'(t - 3));
        checkOutput("pixel_out", 32'(pixel_out), 32'(mem[src_of(t - 3, zoom4)]));
      end
      if (t == abort_at) begin
        enable = 1'b0;
        start  = 1'($urandom);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          checkOutput("abort_write_en", 32'(write_en), 32'd0);
          checkOutput("abort_busy", 32'(busy), 32'd0);
          checkOutput("abort_done", 32'(done), 32'd0);
        end
        enable = 1'b1;
        start  = 1'b0;
        @(negedge clk);
        checkOutput("abort_idle_busy", 32'(busy), 32'd0);
        return;
      end
      start      = (t <= NPIX + 2) ? (($urandom % 4) == 0) : 1'b0;
      zoom_level = 3'($urandom);
    end
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    reset_n    = 1'b0;
    enable     = 1'b0;
    start      = 1'b0;
    zoom_level = 3'd0;
    for (int a = 0; a < 32768; a++) mem[a] = 8'($urandom);

    #3;
    checkIdleOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    applyStimulus(3'd0, -1);
    applyStimulus(3'd1, -1);
    applyStimulus(3'd3, 1000);
    applyStimulus(3'd1, -1);

    @(negedge clk);
    enable     = 1'b1;
    start      = 1'b1;
    zoom_level = 3'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    checkOutput("midframe_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1 checkIdleOutputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("release_busy", 32'(busy), 32'd0);

    applyStimulus(3'd5, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_replication.md
PIXEL_REPLICATION -- requirements
Module: pixel_replication

Interface
REQ-001 SHALL have parameter IMG_W_IN, default 160, source image width in pixels.
REQ-002 SHALL have parameter IMG_H_IN, default 120, source image height in pixels.
REQ-003 SHALL have parameters IMG_W_OUT, default 320, and IMG_H_OUT, default 240, destination framebuffer size.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  block enable; low aborts and holds IDLE.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a frame.
REQ-008 SHALL have port zoom_level  input  3  0 = 2x full image, 1 = 4x centre crop, 2..7 = treated as 0.
REQ-009 SHALL have port pixel_in  input  8  source pixel, valid one cycle after read_addr.
REQ-010 SHALL have port read_addr  output  15  source memory address, registered.
REQ-011 SHALL have port write_addr  output  17  destination address, registered.
REQ-012 SHALL have port pixel_out  output  8  destination pixel, registered.
REQ-013 SHALL have port write_en  output  1  destination write strobe.
REQ-014 SHALL have ports busy  output  1  and done  output  1 (one-cycle frame-complete pulse).

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> FLUSH -> DONE -> IDLE.
REQ-016 IDLE SHALL move to RUN on start=1 with enable=1; start in any other state SHALL be ignored.
REQ-017 SHALL latch zoom_level on the start cycle; later changes SHALL have no effect on the current frame.
REQ-018 RUN SHALL step output coordinates x_out 0..IMG_W_OUT-1 and then y_out 0..IMG_H_OUT-1, raster order, one per cycle, no stalls.
REQ-019 Shift s SHALL be 1 for 2x and 2 for 4x; offsets (x_off,y_off) SHALL be (0,0) for 2x and (IMG_W_IN/4, IMG_H_IN/4) = (40,30) for 4x.
REQ-020 read_addr SHALL be (y_off + (y_out>>s))*IMG_W_IN + x_off + (x_out>>s); maximum value 19199.
REQ-021 For pixel index k = y_out*IMG_W_OUT + x_out, read_addr SHALL be valid in cycle c. pixel_in is sampled in c+1, and pixel_out=pixel_in, write_addr=k and write_en=1 SHALL be driven in c+2.
REQ-022 After the last coordinate (319,239) is issued, the FSM SHALL enter FLUSH for 2 cycles so the pipeline drains, then DONE.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 busy SHALL be 1 in RUN and FLUSH, and 0 otherwise.
REQ-025 write_en SHALL be 0 in every cycle without a valid pipelined pixel; exactly IMG_W_OUT*IMG_H_OUT = 76800 strobes per frame.
REQ-026 enable=0 in any state SHALL, on the next edge, clear counters and the pipeline, set write_en=0, done=0 and busy=0, and enter IDLE; no done pulse is produced for an aborted frame.
REQ-027 start coincident with the done cycle SHALL be ignored; a new frame needs start in IDLE.
REQ-028 Coordinate counters SHALL wrap x_out at IMG_W_OUT-1 with y_out increment; y_out SHALL never exceed IMG_H_OUT-1.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE and clear x_out, y_out and the latched zoom.
REQ-030 reset_n=0 SHALL asynchronously set read_addr=0, write_addr=0, pixel_out=0, write_en=0, busy=0 and done=0.
REQ-031 Reset mid-frame SHALL discard the frame; the first edge after release SHALL see IDLE.

Structure
REQ-032 Shared package img_pkg SHALL hold the image dimension constants, the zoom encodings ZOOM_2X=0 and ZOOM_4X=1, and the FSM state type.
REQ-033 The source-address computation (REQ-019/020) SHALL be a sub-module replication_addr_gen: combinational, x_out/y_out/zoom in, read_addr out.
REQ-034 The multiply by IMG_W_IN SHALL be implemented as shifts and adds ((y<<7)+(y<<5)); no DSP required.

Verification
REQ-035 2x frame, memory[a]=a[7:0], start: write k=0,1,320,321 carry source 0; k=2 carries source 1; 76800 strobes, then done one cycle after FLUSH.
REQ-036 4x frame: first read_addr = 30*160+40 = 4840; k=0..3 on rows 0..3 all use 4840; k=4 uses 4841; last read_addr = 89*160+119 = 14359.
REQ-037 Latency check: read_addr=N at cycle c -> pixel_out/write_addr/write_en at c+2; write_en=0 in the first two RUN cycles.
REQ-038 Drop enable at pixel 1000: next edge write_en=0, busy=0, no done; a fresh start produces a full, correct frame.
REQ-039 Assert reset_n low mid-frame (asynchronous, between edges): all outputs 0 immediately; zoom_level=5 after reset behaves as 2x.
